// File: rtl/io_bitbang_ctrl_pkg.sv
// Shared opcode/status values, FSM state type and counter sizing for io_bitbang_ctrl.
package io_bitbang_ctrl_pkg;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_WR_DIR   = 3'd1;
    localparam logic [2:0] OP_WR_OUT   = 3'd2;
    localparam logic [2:0] OP_READ     = 3'd3;
    localparam logic [2:0] OP_DELAY    = 3'd4;
    localparam logic [2:0] OP_WAIT_PIN = 3'd5;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_BADOP    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESP  = 2'd1,
        S_DELAY = 2'd2,
        S_WAIT  = 2'd3
    } ctrl_state_t;

    // Down-counter must hold the larger of the longest DELAY and the WAIT timeout.
    function automatic int cnt_width(input int io_num, input int timeout);
        int max_count;
        max_count = (2 ** io_num) - 1;
        if (timeout > max_count) max_count = timeout;
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser with synchronous reset for the asynchronous pin inputs.
module io_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_bitbang_ctrl.sv
// Command sequencer for io_bitbang: pin direction/value registers, pin sampling,
// timed DELAY and WAIT_PIN, one response per command.
//
// state   | meaning
// S_IDLE  | ready for a command
// S_RESP  | response held on rsp_* until consumed
// S_DELAY | counting down a DELAY command
// S_WAIT  | polling synchronised pins, counting down the timeout
module io_bitbang_ctrl
    import io_bitbang_ctrl_pkg::*;
#(
    parameter int IO_NUM_OF    = 10,
    parameter int WAIT_TIMEOUT = 1000
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_cmd_valid,
    output logic                 out_cmd_ready,
    input  logic [2:0]           in_cmd_op,
    input  logic [IO_NUM_OF-1:0] in_cmd_data,
    input  logic [IO_NUM_OF-1:0] in_cmd_mask,
    output logic                 out_rsp_valid,
    input  logic                 in_rsp_ready,
    output logic [IO_NUM_OF-1:0] out_rsp_data,
    output logic [1:0]           out_rsp_status,
    output logic [IO_NUM_OF-1:0] out_io_direction,
    output logic [IO_NUM_OF-1:0] out_io_outval,
    input  logic [IO_NUM_OF-1:0] in_io_inputval
);

    localparam int CNT_W = cnt_width(IO_NUM_OF, WAIT_TIMEOUT);

    ctrl_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IO_NUM_OF-1:0] dir_q, dir_d;
    logic [IO_NUM_OF-1:0] outval_q, outval_d;
    logic [IO_NUM_OF-1:0] wait_mask_q, wait_mask_d;
    logic [IO_NUM_OF-1:0] wait_val_q, wait_val_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IO_NUM_OF-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]           rsp_status_q, rsp_status_d;
    logic [IO_NUM_OF-1:0] sync;

    io_sync2 #(.WIDTH(IO_NUM_OF)) u_sync (
        .clk (in_clk),
        .rst (in_rst),
        .d   (in_io_inputval),
        .q   (sync)
    );

    // State, counter and output registers; reset drops any operation in flight.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dir_q        <= '0;
            outval_q     <= '0;
            wait_mask_q  <= '0;
            wait_val_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            outval_q     <= outval_d;
            wait_mask_q  <= wait_mask_d;
            wait_val_q   <= wait_val_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    // Next-state, command decode and response generation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        outval_d     = outval_q;
        wait_mask_d  = wait_mask_q;
        wait_val_d   = wait_val_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            S_IDLE: begin
                if (in_cmd_valid) begin
                    // Default: immediate OK response carrying the current sample.
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = sync;
                    rsp_status_d = ST_OK;
                    case (in_cmd_op)
                        OP_NOP, OP_READ: ;
                        OP_WR_DIR: dir_d = (dir_q & ~in_cmd_mask) | (in_cmd_data & in_cmd_mask);
                        OP_WR_OUT: outval_d = (outval_q & ~in_cmd_mask) | (in_cmd_data & in_cmd_mask);
                        OP_DELAY: begin
                            // A zero delay completes immediately like a NOP.
                            if (in_cmd_data != '0) begin
                                state_d     = S_DELAY;
                                rsp_valid_d = 1'b0;
                                cnt_d       = CNT_W'(in_cmd_data) - CNT_W'(1);
                            end
                        end
                        OP_WAIT_PIN: begin
                            state_d     = S_WAIT;
                            rsp_valid_d = 1'b0;
                            cnt_d       = CNT_W'(WAIT_TIMEOUT - 1);
                            wait_mask_d = in_cmd_mask;
                            wait_val_d  = in_cmd_data & in_cmd_mask;
                        end
                        default: begin
                            rsp_status_d = ST_BADOP;
                            rsp_data_d   = '0;
                        end
                    endcase
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = sync;
                    rsp_status_d = ST_OK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                // A match on the final compare wins over the timeout.
                if ((sync & wait_mask_q) == wait_val_q) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = sync;
                    rsp_status_d = ST_OK;
                end else if (cnt_q == '0) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = sync;
                    rsp_status_d = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (in_rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_cmd_ready    = (state_q == S_IDLE) && !in_rst;
    assign out_rsp_valid    = rsp_valid_q;
    assign out_rsp_data     = rsp_data_q;
    assign out_rsp_status   = rsp_status_q;
    assign out_io_direction = dir_q;
    assign out_io_outval    = outval_q;

endmodule

// File: tb/tb_io_bitbang_ctrl.sv
// Self-checking bench for io_bitbang_ctrl: transaction-level reference model,
// per-cycle compare, directed scenarios and a randomized command stream.
module tb_io_bitbang_ctrl;
    import io_bitbang_ctrl_pkg::*;

    localparam int W    = 10;
    localparam int T    = 20;
    localparam int MAXC = 20000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_op = '0;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] cmd_mask = '0;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] pins = '0;
    logic         cmd_ready, rsp_valid;
    logic [W-1:0] rsp_data, io_dir, io_out;
    logic [1:0]   rsp_status;

    io_bitbang_ctrl #(.IO_NUM_OF(W), .WAIT_TIMEOUT(T)) dut (
        .in_clk           (clk),
        .in_rst           (rst),
        .in_cmd_valid     (cmd_valid),
        .out_cmd_ready    (cmd_ready),
        .in_cmd_op        (cmd_op),
        .in_cmd_data      (cmd_data),
        .in_cmd_mask      (cmd_mask),
        .out_rsp_valid    (rsp_valid),
        .in_rsp_ready     (rsp_ready),
        .out_rsp_data     (rsp_data),
        .out_rsp_status   (rsp_status),
        .out_io_direction (io_dir),
        .out_io_outval    (io_out),
        .in_io_inputval   (pins)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit rand_pins = 1'b0;
    logic [W-1:0] pin_cmd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc);
    endtask

    // Pin stimulus: changes only just after a rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_pins) begin
            if ($urandom_range(0, 2) == 0) pins = W'($urandom);
        end else begin
            pins = pin_cmd;
        end
    end

    // Reference model: pin/reset history gives the synchronised sample; each command
    // resolves to a completion edge with status and data.
    logic [W-1:0] pin_hist [MAXC];
    bit           rst_hist [MAXC];
    bit           m_idle = 1'b1, m_valid = 1'b0;
    logic [1:0]   m_status = '0;
    logic [W-1:0] m_data = '0, m_dir = '0, m_out = '0, m_wmask = '0, m_wval = '0;
    int           m_kind = 0, m_start = 0, m_target = 0;

    function automatic logic [W-1:0] sync_after(input int k);
        if (k < 1 || k >= MAXC) return '0;
        if (rst_hist[k] || rst_hist[k-1]) return '0;
        return pin_hist[k-1];
    endfunction

    initial begin
        rst_hist[0] = 1'b1;
        pin_hist[0] = '0;
        forever begin
            logic [W-1:0] sb;
            bit was_idle;
            @(posedge clk);
            cyc++;
            if (cyc >= MAXC) begin
                $display("FAIL cycle_budget actual=%0d required<%0d", cyc, MAXC);
                $fatal(1, "cycle budget exhausted");
            end
            pin_hist[cyc] = pins;
            rst_hist[cyc] = rst;
            sb = sync_after(cyc - 1);
            if (rst) begin
                m_idle = 1'b1; m_valid = 1'b0; m_kind = 0; m_dir = '0; m_out = '0;
            end else begin
                was_idle = m_idle;
                if (m_valid && rsp_ready) begin
                    m_valid = 1'b0; m_idle = 1'b1;
                end
                if (m_kind == 1 && cyc == m_target) begin
                    m_valid = 1'b1; m_status = ST_OK; m_data = sb; m_kind = 0;
                end else if (m_kind == 2) begin
                    if ((sb & m_wmask) == (m_wval & m_wmask)) begin
                        m_valid = 1'b1; m_status = ST_OK; m_data = sb; m_kind = 0;
                    end else if (cyc - m_start >= T) begin
                        m_valid = 1'b1; m_status = ST_TIMEOUT; m_data = sb; m_kind = 0;
                    end
                end
                if (was_idle && cmd_valid) begin
                    m_idle = 1'b0;
                    m_start = cyc;
                    m_status = ST_OK;
                    m_data = sb;
                    m_valid = 1'b1;
                    case (cmd_op)
                        OP_WR_DIR: m_dir = (m_dir & ~cmd_mask) | (cmd_data & cmd_mask);
                        OP_WR_OUT: m_out = (m_out & ~cmd_mask) | (cmd_data & cmd_mask);
                        OP_DELAY: if (cmd_data != 0) begin
                            m_valid = 1'b0; m_kind = 1; m_target = cyc + int'(cmd_data);
                        end
                        OP_WAIT_PIN: begin
                            m_valid = 1'b0; m_kind = 2; m_wmask = cmd_mask; m_wval = cmd_data;
                        end
                        OP_NOP, OP_READ: ;
                        default: begin m_status = ST_BADOP; m_data = '0; end
                    endcase
                end
            end
        end
    end

    // Per-cycle compare against the model, half a cycle after the edge.
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(m_idle && !rst));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("io_direction", 32'(io_dir), 32'(m_dir));
            chk("io_outval", 32'(io_out), 32'(m_out));
            if (m_valid) begin
                chk("rsp_data", 32'(rsp_data), 32'(m_data));
                chk("rsp_status", 32'(rsp_status), 32'(m_status));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] d, input logic [W-1:0] m,
                        output int acc);
        int n = 0;
        bit got = 1'b0;
        cmd_op = op; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
        while (!got && n < 500) begin
            @(negedge clk);
            got = (cmd_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        acc = cyc;
        chk("cmd_accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_rsp(input int acc, input int hold, output int lat,
                            output logic [1:0] st, output logic [W-1:0] dat);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 3000) begin
            @(negedge clk);
            got = (rsp_valid === 1'b1);
            if (!got) n++;
        end
        chk("rsp_arrives", 32'(got), 32'd1);
        lat = cyc + 1 - acc;
        st  = rsp_status;
        dat = rsp_data;
        if (got) begin
            repeat (hold) @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        int acc, lat;
        logic [1:0]   st;
        logic [W-1:0] dat;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_dir", 32'(io_dir), 32'h0);
        chk("reset_outval", 32'(io_out), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("ready_after_reset", 32'(cmd_ready), 32'h1);
        @(posedge clk);
        #1;

        // Masked direction / output writes.
        send(OP_WR_DIR, 10'h3FF, 10'h00F, acc);
        wait_rsp(acc, 0, lat, st, dat);
        chk("wr_dir_latency", 32'(lat), 32'd1);
        chk("wr_dir_status", 32'(st), 32'(ST_OK));
        send(OP_WR_OUT, 10'h005, 10'h00F, acc);
        wait_rsp(acc, 0, lat, st, dat);
        chk("wr_out_latency", 32'(lat), 32'd1);
        chk("dir_value", 32'(io_dir), 32'h00F);
        chk("outval_value", 32'(io_out), 32'h005);

        // Reset in the middle of a long DELAY.
        send(OP_DELAY, 10'd50, 10'h0, acc);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ready_in_reset", 32'(cmd_ready), 32'h0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_post_reset", 32'(cmd_ready), 32'h1);
        chk("dir_post_reset", 32'(io_dir), 32'h0);
        chk("outval_post_reset", 32'(io_out), 32'h0);
        chk("rsp_valid_post_reset", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;

        // READ through the synchroniser.
        pin_cmd = 10'h2A5;
        repeat (3) @(posedge clk);
        #1;
        send(OP_READ, 10'h0, 10'h0, acc);
        wait_rsp(acc, 0, lat, st, dat);
        chk("read_data", 32'(dat), 32'h2A5);
        chk("read_status", 32'(st), 32'(ST_OK));

        // DELAY boundaries.
        send(OP_DELAY, 10'd5, 10'h0, acc);
        wait_rsp(acc, 1, lat, st, dat);
        chk("delay5_latency", 32'(lat), 32'd6);
        send(OP_DELAY, 10'd0, 10'h0, acc);
        wait_rsp(acc, 0, lat, st, dat);
        chk("delay0_latency", 32'(lat), 32'd1);
        send(OP_DELAY, 10'h3FF, 10'h0, acc);
        wait_rsp(acc, 0, lat, st, dat);
        chk("delay_max_latency", 32'(lat), 32'd1024);

        // WAIT_PIN: pin0 rises 10 cycles after accept, then a timeout case.
        pin_cmd = 10'h0;
        repeat (3) @(posedge clk);
        #1;
        send(OP_WAIT_PIN, 10'h001, 10'h001, acc);
        repeat (9) @(posedge clk);
        pin_cmd = 10'h001;
        wait_rsp(acc, 0, lat, st, dat);
        chk("wait_ok_status", 32'(st), 32'(ST_OK));
        chk("wait_ok_latency", 32'(lat), 32'd13);
        chk("wait_ok_data", 32'(dat), 32'h001);
        pin_cmd = 10'h0;
        repeat (3) @(posedge clk);
        #1;
        send(OP_WAIT_PIN, 10'h001, 10'h001, acc);
        wait_rsp(acc, 0, lat, st, dat);
        chk("wait_to_status", 32'(st), 32'(ST_TIMEOUT));
        chk("wait_to_latency", 32'(lat), 32'(T + 1));
        send(OP_WAIT_PIN, 10'h155, 10'h000, acc);
        wait_rsp(acc, 0, lat, st, dat);
        chk("wait_mask0_latency", 32'(lat), 32'd2);

        // BADOP with response backpressure; a queued NOP must wait for the consume.
        send(3'd7, 10'h3FF, 10'h3FF, acc);
        repeat (4) begin
            @(negedge clk);
            chk("badop_valid_held", 32'(rsp_valid), 32'h1);
            chk("badop_status", 32'(rsp_status), 32'(ST_BADOP));
            chk("badop_data", 32'(rsp_data), 32'h0);
            chk("badop_ready_low", 32'(cmd_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        cmd_op = OP_NOP; cmd_valid = 1'b1;
        @(negedge clk);
        chk("nop_blocked", 32'(cmd_ready), 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_consume", 32'(cmd_ready), 32'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc = cyc;
        wait_rsp(acc, 0, lat, st, dat);
        chk("nop_latency", 32'(lat), 32'd1);

        // Randomized command stream against the model.
        rand_pins = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [2:0]   op;
            logic [W-1:0] d, m;
            op = 3'($urandom_range(0, 7));
            d  = W'($urandom);
            m  = W'($urandom) & W'($urandom) & W'($urandom);
            if (op == OP_DELAY) d = W'($urandom_range(0, 25));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(op, d, m, acc);
            wait_rsp(acc, $urandom_range(0, 3), lat, st, dat);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
